ps2_scan_decoder: RTL and testbench

- Read-side controller for the PS/2 receive byte FIFO.
- Pops raw scan-code bytes from the FIFO, then strips and tracks the E0 (extended), F0 (break) and E1 (pause) prefixes.
- Emits one complete key event per keystroke on a valid/ready interface to downstream logic.
- Splits device status bytes (BAT, ACK, resend, error) out as single-cycle pulses.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_evt_reg.sv | 49 ++++
 rtl/ps2_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and decoder state type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_ERR0       = 8'h00;
  localparam logic [7:0] PS2_ERR1       = 8'hFF;
  localparam logic [7:0] PS2_BAT_FAIL   = 8'hFC;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

  typedef enum logic {NORMAL, SKIP} ps2_state_e;

  function automatic logic ps2_is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_evt_reg.sv
// Single-entry valid/ready holding register for the decoded key event bundle.
module ps2_evt_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_brk,
  input  logic       i_pause,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_code,
  output logic       o_ext,
  output logic       o_brk,
  output logic       o_pause
);

  logic       r_valid;
  logic [7:0] r_code;
  logic       r_ext;
  logic       r_brk;
  logic       r_pause;

  // A load on the accepting edge replaces the old event with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= 8'h00;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_pause <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_code  <= i_code;
      r_ext   <= i_ext;
      r_brk   <= i_brk;
      r_pause <= i_pause;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_code  = r_code;
  assign o_ext   = r_ext;
  assign o_brk   = r_brk;
  assign o_pause = r_pause;

endmodule

// File: rtl/ps2_scan_decoder.sv
// Pops PS/2 scan bytes from a FWFT FIFO, strips E0/F0/E1 prefixes and emits key events.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned D_WIDTH        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned PAUSE_TAIL     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_data,
  output logic               fifo_rd,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_brk,
  output logic               evt_pause,
  output logic               dev_bat_ok,
  output logic               dev_ack,
  output logic               dev_resend,
  output logic               dev_err,
  output logic               prefix_timeout
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = (PAUSE_TAIL > 1) ? $clog2(PAUSE_TAIL + 1) : 1;

  ps2_state_e    r_state;
  logic          r_ext;
  logic          r_brk;
  logic [SW-1:0] r_skip;
  logic [TW-1:0] r_to_cnt;
  logic          r_bat_ok;
  logic          r_ack;
  logic          r_resend;
  logic          r_err;
  logic          r_timeout;

  logic [7:0] w_byte;
  logic       w_pop;
  logic       w_evt_valid;
  logic       w_load;
  logic [7:0] w_code;
  logic       w_ext;
  logic       w_brk;
  logic       w_pause;
  logic       w_pending;

  assign w_byte    = fifo_data[7:0];
  assign w_pop     = !rst && !fifo_empty && (!w_evt_valid || evt_ready);
  assign fifo_rd   = w_pop;
  assign w_pending = r_ext || r_brk || (r_state == SKIP);

  always_comb begin
    w_load  = 1'b0;
    w_code  = w_byte;
    w_ext   = r_ext;
    w_brk   = r_brk;
    w_pause = 1'b0;
    if (w_pop) begin
      if (r_state == NORMAL) begin
        if (w_byte == PS2_PAUSE) begin
          if (PAUSE_TAIL == 0) begin
            w_load  = 1'b1;
            w_code  = PS2_PAUSE_CODE;
            w_ext   = 1'b0;
            w_brk   = 1'b0;
            w_pause = 1'b1;
          end
        end else if (w_byte != PS2_EXT && w_byte != PS2_BRK && !ps2_is_status(w_byte)) begin
          w_load = 1'b1;
        end
      end else if (r_skip == SW'(1)) begin
        w_load  = 1'b1;
        w_code  = PS2_PAUSE_CODE;
        w_ext   = 1'b0;
        w_brk   = 1'b0;
        w_pause = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NORMAL;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_skip    <= '0;
      r_to_cnt  <= '0;
      r_bat_ok  <= 1'b0;
      r_ack     <= 1'b0;
      r_resend  <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_bat_ok  <= 1'b0;
      r_ack     <= 1'b0;
      r_resend  <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      if (w_pop) begin
        r_to_cnt <= '0;
        unique case (r_state)
          NORMAL: begin
            if (w_byte == PS2_EXT) begin
              r_ext <= 1'b1;
            end else if (w_byte == PS2_BRK) begin
              r_brk <= 1'b1;
            end else if (w_byte == PS2_PAUSE) begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
              if (PAUSE_TAIL != 0) begin
                r_state <= SKIP;
                r_skip  <= SW'(PAUSE_TAIL);
              end
            end else if (ps2_is_status(w_byte)) begin
              // Status bytes leave any pending prefix untouched.
              r_bat_ok <= (w_byte == PS2_BAT_OK);
              r_ack    <= (w_byte == PS2_ACK);
              r_resend <= (w_byte == PS2_RESEND);
              r_err    <= (w_byte == PS2_ERR0) || (w_byte == PS2_ERR1) ||
                          (w_byte == PS2_BAT_FAIL);
            end else begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
          end
          SKIP: begin
            r_skip <= r_skip - SW'(1);
            if (r_skip == SW'(1)) begin
              r_state <= NORMAL;
            end
          end
        endcase
      end else if (w_pending && fifo_empty) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state   <= NORMAL;
          r_ext     <= 1'b0;
          r_brk     <= 1'b0;
          r_skip    <= '0;
          r_to_cnt  <= '0;
          r_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  ps2_evt_reg u_evt_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_code  (w_code),
    .i_ext   (w_ext),
    .i_brk   (w_brk),
    .i_pause (w_pause),
    .i_ready (evt_ready),
    .o_valid (w_evt_valid),
    .o_code  (evt_code),
    .o_ext   (evt_ext),
    .o_brk   (evt_brk),
    .o_pause (evt_pause)
  );

  assign evt_valid      = w_evt_valid;
  assign dev_bat_ok     = r_bat_ok;
  assign dev_ack        = r_ack;
  assign dev_resend     = r_resend;
  assign dev_err        = r_err;
  assign prefix_timeout = r_timeout;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench: keystroke-level stimulus queues expected events, a monitor checks them.
module tb_ps2_scan_decoder;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_pause;
  logic       dev_bat_ok;
  logic       dev_ack;
  logic       dev_resend;
  logic       dev_err;
  logic       prefix_timeout;

  always #5 clk = ~clk;

  ps2_scan_decoder #(
    .D_WIDTH        (8),
    .TIMEOUT_CYCLES (TO),
    .PAUSE_TAIL     (7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_rd        (fifo_rd),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_brk        (evt_brk),
    .evt_pause      (evt_pause),
    .dev_bat_ok     (dev_bat_ok),
    .dev_ack        (dev_ack),
    .dev_resend     (dev_resend),
    .dev_err        (dev_err),
    .prefix_timeout (prefix_timeout)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } evt_t;

  evt_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0;
  int errors = 0;
  int n_bat = 0, n_ack = 0, n_resend = 0, n_err = 0, n_to = 0;
  int e_bat = 0, e_ack = 0, e_resend = 0, e_err = 0, e_to = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  initial begin
    bit   stalled = 0;
    logic [11:0] held;
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled)
          check("stall_hold", {evt_valid, evt_code, evt_ext, evt_brk, evt_pause}, held);
        if (evt_valid && !evt_ready)
          check("no_pop_while_stalled", fifo_rd, 0);
        if (!evt_valid && !fifo_empty)
          check("pop_when_free", fifo_rd, 1);
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_evt", {evt_code, evt_ext, evt_brk, evt_pause}, 12'hfff);
          end else begin
            e = exp_q.pop_front();
            check("evt", {evt_code, evt_ext, evt_brk, evt_pause}, e);
          end
        end
        stalled = evt_valid && !evt_ready;
        held = {evt_valid, evt_code, evt_ext, evt_brk, evt_pause};
        n_bat    += int'(dev_bat_ok);
        n_ack    += int'(dev_ack);
        n_resend += int'(dev_resend);
        n_err    += int'(dev_err);
        n_to     += int'(prefix_timeout);
      end
    end
  end

  // One clock: drive the FIFO head, note whether the DUT pops, consume after the edge.
  task automatic step();
    logic p;
    if (rand_ready) evt_ready = ($urandom_range(0, 3) != 0);
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    #1 p = fifo_rd;
    @(posedge clk);
    #1;
    if (p) void'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || evt_valid) && k < 2000) begin
      step();
      k++;
    end
    check("drain_bound", (k < 2000), 1);
  endtask

  task automatic push_status(input logic [7:0] b);
    fifo_q.push_back(b);
    case (b)
      8'hAA:                 e_bat++;
      8'hFA:                 e_ack++;
      8'hFE:                 e_resend++;
      8'h00, 8'hFF, 8'hFC:   e_err++;
      default:               ;
    endcase
  endtask

  function automatic logic [7:0] rand_status();
    logic [7:0] tbl [6];
    tbl = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hFC};
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom_range(1, 254));
    while (c inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hFC});
    return c;
  endfunction

  // A keystroke as the keyboard sends it; optional status byte after the prefixes.
  task automatic push_key(input logic [7:0] code, input logic ext, input logic brk,
                          input bit with_status);
    evt_t e;
    if (ext) fifo_q.push_back(8'hE0);
    if (with_status) push_status(rand_status());
    if (brk) fifo_q.push_back(8'hF0);
    fifo_q.push_back(code);
    e = '{code: code, ext: ext, brk: brk, pause: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_pause(input bit rand_tail);
    logic [7:0] tail [7];
    evt_t e;
    tail = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    fifo_q.push_back(8'hE1);
    for (int i = 0; i < 7; i++)
      fifo_q.push_back(rand_tail ? 8'($urandom_range(0, 255)) : tail[i]);
    e = '{code: 8'h77, ext: 1'b0, brk: 1'b0, pause: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_fields"}, {evt_code, evt_ext, evt_brk, evt_pause}, 0);
    check({tag, "_pulses"}, {dev_bat_ok, dev_ack, dev_resend, dev_err, prefix_timeout}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_t e;
    rst        = 1'b1;
    evt_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    @(posedge clk);
    #1;
    // Reset state, with a byte already waiting: no pop while in reset.
    fifo_q.push_back(8'h1C);
    e = '{code: 8'h1C, ext: 1'b0, brk: 1'b0, pause: 1'b0};
    exp_q.push_back(e);
    steps(2);
    check_reset_outputs("reset");
    fifo_empty = 1'b0;
    fifo_data  = 8'h1C;
    #1 check("rd_in_reset", fifo_rd, 0);

    // Single make code: popped at this edge, visible in the next cycle.
    rst = 1'b0;
    step();
    check("latency_valid", evt_valid, 1);
    check("latency_code", evt_code, 8'h1C);
    check("popped_once", fifo_q.size(), 0);
    drain();

    // Extended release, then a plain make to show flags cleared.
    push_key(8'h74, 1'b1, 1'b1, 1'b0);
    push_key(8'h1C, 1'b0, 1'b0, 1'b0);
    drain();

    // Pause sequence yields exactly one event.
    push_pause(1'b0);
    drain();

    // Stall: first event held, second byte stays in the FIFO.
    evt_ready = 1'b0;
    push_key(8'h1C, 1'b0, 1'b0, 1'b0);
    push_key(8'h32, 1'b0, 1'b0, 1'b0);
    steps(6);
    check("stall_valid", evt_valid, 1);
    check("stall_code", evt_code, 8'h1C);
    check("stall_fifo_left", fifo_q.size(), 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("nobubble_valid", evt_valid, 1);
    check("nobubble_code", evt_code, 8'h32);
    steps(2);
    evt_ready = 1'b1;
    drain();

    // Stale break prefix is discarded after the idle timeout.
    fifo_q.push_back(8'hF0);
    e_to++;
    steps(TO + 8);
    check("timeout_count", n_to, e_to);
    push_key(8'h1C, 1'b0, 1'b0, 1'b0);
    drain();

    // Status byte between prefix and code keeps the prefix.
    fifo_q.push_back(8'hF0);
    push_status(8'hFA);
    fifo_q.push_back(8'h1C);
    e = '{code: 8'h1C, ext: 1'b0, brk: 1'b1, pause: 1'b0};
    exp_q.push_back(e);
    drain();
    check("ack_count", n_ack, e_ack);

    // Reset after the prefix discards it.
    fifo_q.push_back(8'hF0);
    steps(2);
    rst = 1'b1;
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    push_key(8'h1C, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomised keystrokes, status bytes and pauses with random back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        push_key(rand_code(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
      else if (sel < 9)
        push_status(rand_status());
      else
        push_pause(1'b1);
      steps($urandom_range(0, 3));
    end
    drain();
    rand_ready = 0;
    evt_ready  = 1'b1;
    steps(4);

    check("bat_total", n_bat, e_bat);
    check("ack_total", n_ack, e_ack);
    check("resend_total", n_resend, e_resend);
    check("err_total", n_err, e_err);
    check("timeout_total", n_to, e_to);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
